// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flop channels switchable between SR, JK, D and T behaviour,
// with sticky illegal-SR flags, a change pulse and a saturating change counter.

module multi_ff_bank_lane #(
    parameter int SR_POLICY = 0
) (
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_nxt,
    output logic       illegal
);
    always_comb begin
        q_nxt   = q;
        illegal = 1'b0;
        case (mode)
            2'b00: begin
                case ({a, b})
                    2'b10: q_nxt = 1'b1;
                    2'b01: q_nxt = 1'b0;
                    2'b11: begin
                        // Flag is policy-independent; only the resolved value differs.
                        illegal = 1'b1;
                        if (SR_POLICY == 1)      q_nxt = 1'b1;
                        else if (SR_POLICY == 2) q_nxt = 1'b0;
                    end
                    default: q_nxt = q;
                endcase
            end
            2'b01: begin
                case ({a, b})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            2'b10:   q_nxt = a;
            default: q_nxt = q ^ a;
        endcase
    end
endmodule

module multi_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] err,
    output logic             chg,
    output logic [CNT_W-1:0] cnt
);
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] illegal;
    logic             changed;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            multi_ff_bank_lane #(.SR_POLICY(SR_POLICY)) u_lane (
                .mode    (mode),
                .a       (a[i]),
                .b       (b[i]),
                .q       (q[i]),
                .q_nxt   (q_nxt[i]),
                .illegal (illegal[i])
            );
        end
    endgenerate

    assign changed = en && (q_nxt != q);
    assign q_bar   = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RESET_VAL;
            err <= '0;
            chg <= 1'b0;
            cnt <= '0;
        end else begin
            if (en)
                q <= q_nxt;
            chg <= changed;
            // A new illegal condition wins over a simultaneous clear.
            err <= (err_clr ? '0 : err) | (en ? illegal : '0);
            if (err_clr)
                cnt <= '0;
            else if (changed && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_ff_bank.sv
// Directed bench for multi_ff_bank: four instances share stimulus and differ in
// SR_POLICY and CNT_W so policy and saturation behaviour are observed side by side.

module tb_multi_ff_bank;
    logic       clk = 1'b0;
    logic       rst, en, err_clr;
    logic [1:0] mode;
    logic [7:0] a, b;

    logic [7:0] q0, qb0, e0, q1, qb1, e1, q2, qb2, e2, q3, qb3, e3;
    logic       c0, c1, c2, c3;
    logic [7:0] n0, n1, n2;
    logic [1:0] n3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q0), .q_bar(qb0), .err(e0), .chg(c0), .cnt(n0));
    multi_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(1), .CNT_W(8)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q1), .q_bar(qb1), .err(e1), .chg(c1), .cnt(n1));
    multi_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(2), .CNT_W(8)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q2), .q_bar(qb2), .err(e2), .chg(c2), .cnt(n2));
    multi_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(0), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q3), .q_bar(qb3), .err(e3), .chg(c3), .cnt(n3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic clr,
                        input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv);
        rst = r; en = e; err_clr = clr; mode = m; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        step(1, 1, 1, 2'b11, 8'hFF, 8'hFF);
        chk("rst_q", q0, 8'hA5);    chk("rst_qbar", qb0, 8'h5A);
        chk("rst_err", e0, 8'h00);  chk("rst_chg", c0, 1'b0);
        chk("rst_cnt", n0, 0);      chk("rst_cnt_c2", n3, 0);

        // D to zero, then SR set/clear
        step(0, 1, 0, 2'b10, 8'h00, 8'hFF);
        chk("d0_q", q0, 8'h00); chk("d0_chg", c0, 1'b1); chk("d0_cnt", n0, 1);
        step(0, 1, 0, 2'b00, 8'h0F, 8'hF0);
        chk("sr_q", q0, 8'h0F); chk("sr_qbar", qb0, 8'hF0); chk("sr_cnt", n0, 2);

        // S=R=1 on bit0 while bit0=1
        step(0, 1, 0, 2'b00, 8'h01, 8'h01);
        chk("srx_p0_q", q0, 8'h0F); chk("srx_p1_q", q1, 8'h0F); chk("srx_p2_q", q2, 8'h0E);
        chk("srx_p0_err", e0, 8'h01); chk("srx_p1_err", e1, 8'h01); chk("srx_p2_err", e2, 8'h01);
        chk("srx_chg", c0, 1'b0); chk("srx_cnt", n0, 2);

        // back to zero; err sticky through D mode
        step(0, 1, 0, 2'b10, 8'h00, 8'h00);
        chk("d1_q", q0, 8'h00); chk("d1_err_sticky", e0, 8'h01); chk("d1_cnt", n0, 3);

        // S=R=1 on bit0 while bit0=0
        step(0, 1, 0, 2'b00, 8'h01, 8'h01);
        chk("srx0_p0_q", q0, 8'h00); chk("srx0_p1_q", q1, 8'h01); chk("srx0_p2_q", q2, 8'h00);
        chk("srx0_p1_chg", c1, 1'b1);

        // err_clr together with a q change on p1 only
        step(0, 1, 1, 2'b10, 8'h00, 8'h00);
        chk("clr_p0_err", e0, 8'h00); chk("clr_p0_cnt", n0, 0); chk("clr_p0_chg", c0, 1'b0);
        chk("clr_p1_q", q1, 8'h00); chk("clr_p1_cnt", n1, 0); chk("clr_p1_chg", c1, 1'b1);

        // JK toggle x3
        step(0, 1, 0, 2'b01, 8'hFF, 8'hFF);
        chk("jk1_q", q0, 8'hFF); chk("jk1_chg", c0, 1'b1);
        step(0, 1, 0, 2'b01, 8'hFF, 8'hFF);
        chk("jk2_q", q0, 8'h00); chk("jk2_chg", c0, 1'b1);
        step(0, 1, 0, 2'b01, 8'hFF, 8'hFF);
        chk("jk3_q", q0, 8'hFF); chk("jk3_chg", c0, 1'b1);
        chk("jk3_cnt", n0, 3); chk("jk3_err", e0, 8'h00); chk("jk3_c2_cnt", n3, 3);

        // two more changing edges: c2 saturates
        step(0, 1, 0, 2'b01, 8'hFF, 8'hFF);
        chk("jk4_q", q0, 8'h00); chk("jk4_c2_cnt", n3, 3);
        step(0, 1, 0, 2'b01, 8'hFF, 8'hFF);
        chk("jk5_cnt", n0, 5); chk("jk5_c2_cnt", n3, 3);

        // T mode with en gating
        step(0, 1, 0, 2'b10, 8'h00, 8'h00);
        chk("t_pre_q", q0, 8'h00); chk("t_pre_cnt", n0, 6);
        step(0, 1, 0, 2'b11, 8'h01, 8'hFF);
        chk("t1_q", q0, 8'h01); chk("t1_chg", c0, 1'b1);
        step(0, 0, 0, 2'b11, 8'h01, 8'hFF);
        chk("t2_q", q0, 8'h01); chk("t2_chg", c0, 1'b0); chk("t2_cnt", n0, 7);
        step(0, 1, 0, 2'b11, 8'h01, 8'hFF);
        chk("t3_q", q0, 8'h00); chk("t3_chg", c0, 1'b1); chk("t3_cnt", n0, 8);

        // err_clr with a simultaneous illegal SR on bit2
        step(0, 1, 1, 2'b00, 8'h04, 8'h04);
        chk("clrset_c2_err", e3, 8'h04); chk("clrset_c2_cnt", n3, 0);
        chk("clrset_p0_q", q0, 8'h00); chk("clrset_p1_q", q1, 8'h04); chk("clrset_p1_err", e1, 8'h04);

        // T toggling, then reset mid-stream
        step(0, 1, 0, 2'b11, 8'hFF, 8'h00);
        chk("tt_q", q0, 8'hFF); chk("tt_cnt", n0, 1);
        step(1, 1, 1, 2'b11, 8'hFF, 8'h00);
        chk("mid_rst_q", q0, 8'hA5); chk("mid_rst_qbar", qb0, 8'h5A);
        chk("mid_rst_chg", c0, 1'b0); chk("mid_rst_cnt", n0, 0); chk("mid_rst_err", e0, 8'h00);
        step(0, 0, 0, 2'b11, 8'hFF, 8'h00);
        chk("post_rst_chg", c0, 1'b0); chk("post_rst_q", q0, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_ff_bank.md
MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent flip-flop channels (1..32).
REQ-002 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}: q value loaded on reset.
REQ-003 SHALL have parameter SR_POLICY, default 0: S=R=1 handling in SR mode (0 hold, 1 set-dominant, 2 reset-dominant).
REQ-004 SHALL have parameter CNT_W, default 8: width of the change counter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: global update enable; when low, all channels hold.
REQ-008 SHALL have port mode, input, 2 bits: 00 SR, 01 JK, 10 D, 11 T; applies to all channels and is sampled every cycle.
REQ-009 SHALL have port a, input, WIDTH bits: per-channel S/J/D/T input.
REQ-010 SHALL have port b, input, WIDTH bits: per-channel R/K input; ignored in D and T modes.
REQ-011 SHALL have port err_clr, input, 1 bit: synchronous clear of the err and cnt state.
REQ-012 SHALL have port q, output, WIDTH bits: registered channel state.
REQ-013 SHALL have port q_bar, output, WIDTH bits: always the bitwise inverse of q, with no illegal or X state.
REQ-014 SHALL have port err, output, WIDTH bits: sticky per-channel flag for illegal S=R=1 seen in SR mode.
REQ-015 SHALL have port chg, output, 1 bit: registered one-cycle pulse; high when at least one q bit changed on the previous edge.
REQ-016 SHALL have port cnt, output, CNT_W bits: saturating count of edges on which any q bit changed.

Function
REQ-017 SHALL, per channel, on a rising edge with en=1 and rst=0, compute next q as follows:
- SR mode: (a,b)=00 hold; 10 set; 01 clear; 11 per SR_POLICY.
- JK mode: 00 hold; 10 set; 01 clear; 11 toggle.
- D mode: q=a.
- T mode: q toggles where a=1 and holds where a=0.
REQ-018 SHALL hold all q bits when en=0, regardless of mode, a and b.
REQ-019 SHALL set err[i] on any enabled edge where mode=SR and a[i]=b[i]=1, independent of SR_POLICY.
REQ-020 SHALL keep err[i] set until rst or err_clr.
REQ-021 SHALL NOT set err in JK, D or T modes.
REQ-022 SHALL assert chg exactly one cycle after an edge on which q differed from its prior value, and deassert it otherwise.
REQ-023 SHALL increment cnt by 1 on each edge on which chg is asserted, saturating at 2^CNT_W-1 with no wrap.
REQ-024 SHALL, on an edge where err_clr=1 and a new illegal condition occur together, leave err[i] set for the new condition; set wins over clear.
REQ-025 SHALL, on an edge where err_clr=1 and a q change occur together, load cnt=0; chg still pulses on the following cycle.
REQ-026 SHALL let err_clr leave q untouched.
REQ-027 SHALL apply a mode change on the same edge it is sampled, with no pipeline latency; q carries over unchanged.
REQ-028 SHALL hold q changes to a latency of one clock from input to q.
REQ-029 SHALL produce no X on any output for any 0/1 input combination.

Reset
REQ-030 SHALL, while rst=1 at a rising edge, load q=RESET_VAL, q_bar=~RESET_VAL, err=0, chg=0 and cnt=0.
REQ-031 SHALL give rst priority over en, err_clr and all data inputs.
REQ-032 SHALL let rst asserted mid-operation discard any pending toggle or set, and SHALL suppress chg on the cycle after reset even if q changed.

Verification
REQ-033 SHALL cover: rst=1 one cycle, RESET_VAL=8'hA5 -> q=8'hA5, q_bar=8'h5A, err=0, chg=0, cnt=0.
REQ-034 SHALL cover: mode=SR, a=8'h0F, b=8'hF0, en=1 from q=0 -> q=8'h0F; then a=b=8'h01 with SR_POLICY=0 -> q bit0 held, err=8'h01; SR_POLICY=1 -> bit0=1; SR_POLICY=2 -> bit0=0.
REQ-035 SHALL cover: mode=JK, a=b=8'hFF for 3 edges from q=0 -> q=FF, 00, FF; chg high each following cycle; cnt=3; err stays 0.
REQ-036 SHALL cover: mode=T, a=8'h01, en toggling 1,0,1 -> q bit0 = 1, 1, 0; chg pulses only after enabled edges.
REQ-037 SHALL cover: CNT_W=2, 5 changing edges -> cnt=3 (saturated); err_clr with simultaneous illegal SR on bit2 -> err=8'h04, cnt=0.
REQ-038 SHALL cover: rst asserted during T-mode toggling with a=FF -> q=RESET_VAL next edge, chg=0 the cycle after.
